// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout and bit positions used by ID/EX.
package id_ex_stage_reg_pkg;

  localparam int unsigned CTRL_W          = 10;
  localparam int unsigned CTRL_ALU_SRC    = 0;
  localparam int unsigned CTRL_REG_WRITE  = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_MEM_TO_REG = 4;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_ALU_OP_LSB = 6;
  localparam int unsigned CTRL_ALU_OP_W   = 4;

  // Field view of the control bundle; member order matches the bit indices above.
  typedef struct packed {
    logic [CTRL_ALU_OP_W-1:0] alu_op;
    logic                     branch;
    logic                     mem_to_reg;
    logic                     mem_write;
    logic                     mem_read;
    logic                     reg_write;
    logic                     alu_src;
  } ctrl_t;

  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use compare between the load sitting in EX and the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             hazard_o
);

  logic rd_nonzero;
  logic src_match;

  // Register 0 is hard-wired, so a load targeting it can never feed a consumer.
  assign rd_nonzero = (ex_rd_i != '0);
  assign src_match  = (id_rs_i == ex_rd_i) | (id_rt_i == ex_rd_i);
  assign hazard_o   = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, stall generation and a
// saturating count of inserted bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              alu_src,
  output logic [CNT_W-1:0]  stall_count
);

  logic              ex_valid_q,    ex_valid_d;
  logic [DATA_W-1:0] ex_rs_data_q,  ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,  ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
  logic [REG_W-1:0]  ex_rs_q,       ex_rs_d;
  logic [REG_W-1:0]  ex_rt_q,       ex_rt_d;
  logic [REG_W-1:0]  ex_rd_q,       ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              hazard;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (is_load(ex_ctrl_q)),
    .ex_rd_i       (ex_rd_q),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .hazard_o      (hazard)
  );

  // A flush discards whatever is stalled, so it never asks the front end to hold.
  assign stall = ~flush & (hazard | ex_hold);

  // Next-state: flush > hold > hazard bubble > normal capture.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs_data_d  = ex_rs_data_q;
    ex_rt_data_d  = ex_rt_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    stall_count_d = stall_count_q;

    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else if (!ex_hold) begin
      if (hazard) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        if (stall_count_q != {CNT_W{1'b1}}) begin
          stall_count_d = stall_count_q + CNT_W'(1);
        end
      end else begin
        ex_valid_d   = id_valid;
        ex_rs_data_d = id_rs_data;
        ex_rt_data_d = id_rt_data;
        ex_imm_d     = id_imm;
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_rd_d      = id_rd;
        // An empty ID slot enters EX as a side-effect-free bubble.
        ex_ctrl_d    = id_valid ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign alu_src     = ex_ctrl_q[CTRL_ALU_SRC];
  assign stall_count = stall_count_q;

endmodule
